// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder for the pipelined 32-bit CPU.
// Takes decoded load/store controls from EX/MEM, runs each access on a
// ready/grant data bus, aligns and extends load data, and holds the pipeline
// stalled until the access completes, errors out, or times out.
module mem_access_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mem_en,
  input  logic [3:0]  i_mem_read,
  input  logic [3:0]  i_mem_write,
  input  logic        i_mem_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_mask;
  logic [1:0]        r_off;
  logic              r_sign;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_err;

  logic [3:0]        w_mask;
  logic              w_access;
  logic              w_mask_ok;
  logic              w_both;
  logic              w_misalign;
  logic              w_illegal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_shift;
  logic [31:0]       w_load;
  logic              w_last;

  // Only one of the two masks may be set for a legal access, so OR-ing them
  // gives the access size regardless of direction.
  assign w_mask     = i_mem_read | i_mem_write;
  assign w_access   = i_mem_en & (|w_mask);
  assign w_mask_ok  = (w_mask == 4'b0001) | (w_mask == 4'b0011) | (w_mask == 4'b1111);
  assign w_both     = (|i_mem_read) & (|i_mem_write);
  assign w_misalign = ((w_mask == 4'b0011) & i_addr[0]) |
                      ((w_mask == 4'b1111) & (|i_addr[1:0]));
  assign w_illegal  = w_both | ~w_mask_ok | w_misalign;
  assign w_be       = w_mask << i_addr[1:0];
  assign w_shift    = i_bus_rdata >> {r_off, 3'b000};
  assign w_last     = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Replicate store data into every lane so the byte enables pick the right one.
  always_comb begin
    w_wdata_rep = i_wdata;
    case (w_mask)
      4'b0001: w_wdata_rep = {4{i_wdata[7:0]}};
      4'b0011: w_wdata_rep = {2{i_wdata[15:0]}};
      default: w_wdata_rep = i_wdata;
    endcase
  end

  // Shift the addressed lane down and zero/sign extend to 32 bits.
  always_comb begin
    w_load = w_shift;
    case (r_mask)
      4'b0001: w_load = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
      4'b0011: w_load = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Stall whenever an access is starting or in flight; RESP releases the pipeline.
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      S_IDLE:   o_stall = w_access & rst_n;
      S_REQ:    o_stall = 1'b1;
      S_WAIT_R: o_stall = 1'b1;
      S_RESP:   o_stall = 1'b0;
      default:  o_stall = 1'b0;
    endcase
  end

  // Access FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_off         <= '0;
      r_sign        <= 1'b0;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_be      <= '0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= S_RESP;
            end else begin
              r_mask      <= w_mask;
              r_off       <= i_addr[1:0];
              r_sign      <= i_mem_sign_ext;
              r_bus_we    <= |i_mem_write;
              r_bus_be    <= w_be;
              r_bus_addr  <= {i_addr[31:2], 2'b00};
              r_bus_wdata <= w_wdata_rep;
              r_bus_req   <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_bus_gnt && r_bus_we) begin
            r_bus_req <= 1'b0;
            r_state   <= S_RESP;
          end else if (w_last) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (i_bus_gnt) begin
              r_bus_req <= 1'b0;
              r_state   <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (i_bus_rvalid) begin
            r_rdata       <= w_load;
            r_rdata_valid <= 1'b1;
            r_state       <= S_RESP;
          end else if (w_last) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_req     = r_bus_req;
  assign o_bus_we      = r_bus_we;
  assign o_bus_be      = r_bus_be;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_err         = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: acts as both the pipeline and the data bus,
// predicting each access outcome into a scoreboard queue and comparing when
// the unit releases the stall.
module tb_mem_access_unit;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        i_mem_en;
  logic [3:0]  i_mem_read;
  logic [3:0]  i_mem_write;
  logic        i_mem_sign_ext;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic        valid;
    logic        chkRdata;
    logic [31:0] rdata;
    int          reqCycles;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mem_en       (i_mem_en),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_sign_ext (i_mem_sign_ext),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .o_stall        (o_stall),
    .o_rdata        (o_rdata),
    .o_rdata_valid  (o_rdata_valid),
    .o_err          (o_err),
    .o_bus_req      (o_bus_req),
    .o_bus_we       (o_bus_we),
    .o_bus_be       (o_bus_be),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_gnt      (i_bus_gnt),
    .i_bus_rvalid   (i_bus_rvalid),
    .i_bus_rdata    (i_bus_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one memory op end to end. rvDelay < 0 withholds rvalid entirely.
  task automatic applyStimulus(input string name, input logic [3:0] rd, input logic [3:0] wr,
                               input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                               input int gntDelay, input int rvDelay, input logic [31:0] busRdata);
    exp_t        e;
    exp_t        g;
    logic [3:0]  mask;
    logic [1:0]  off;
    logic        legal;
    logic        isRead;
    logic        tmo;
    logic [31:0] s;
    logic [7:0]  beWide;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    int          reqCnt;
    int          stalls;
    int          sinceGnt;
    bit          gntDone;
    bit          done;

    mask   = rd | wr;
    off    = addr[1:0];
    legal  = !((rd != 4'd0) && (wr != 4'd0)) &&
             (mask == 4'b0001 || mask == 4'b0011 || mask == 4'b1111) &&
             !(mask == 4'b0011 && addr[0]) && !(mask == 4'b1111 && off != 2'd0);
    isRead = (rd != 4'd0);
    tmo    = legal && isRead && (rvDelay < 0);
    s      = busRdata >> (8 * off);
    beWide = {4'b0000, mask} << off;
    expBe  = beWide[3:0];
    if (mask == 4'b0001)      expWdata = {4{wdata[7:0]}};
    else if (mask == 4'b0011) expWdata = {2{wdata[15:0]}};
    else                      expWdata = wdata;

    e.err      = !legal || tmo;
    e.valid    = legal && isRead && !tmo;
    e.chkRdata = e.valid || tmo;
    if (tmo)                  e.rdata = 32'h0;
    else if (mask == 4'b0001) e.rdata = {{24{sext & s[7]}}, s[7:0]};
    else if (mask == 4'b0011) e.rdata = {{16{sext & s[15]}}, s[15:0]};
    else                      e.rdata = s;
    e.reqCycles = legal ? gntDelay + 1 : 0;
    if (!legal)      e.stalls = 1;
    else if (tmo)    e.stalls = TIMEOUT + 1;
    else if (isRead) e.stalls = 3 + gntDelay + rvDelay;
    else             e.stalls = 2 + gntDelay;
    sb.push_back(e);

    reqCnt = 0; stalls = 0; sinceGnt = 0; gntDone = 0; done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      i_mem_en       = 1'b1;
      i_mem_read     = rd;
      i_mem_write    = wr;
      i_mem_sign_ext = sext;
      i_addr         = addr;
      i_wdata        = wdata;
      i_bus_rdata    = busRdata;
      i_bus_gnt      = o_bus_req && !gntDone && (reqCnt == gntDelay);
      i_bus_rvalid   = isRead && gntDone && (rvDelay >= 0) && (sinceGnt == rvDelay);
      #1;
      if (cyc == 0) checkOutput({name, ".idle_gap"}, 32'(o_bus_req), 32'd0);
      if (o_stall) stalls++;
      if (o_bus_req) begin
        reqCnt++;
        checkOutput({name, ".be"},   32'(o_bus_be), 32'(expBe));
        checkOutput({name, ".addr"}, o_bus_addr, {addr[31:2], 2'b00});
        checkOutput({name, ".we"},   32'(o_bus_we), 32'(!isRead));
        if (!isRead) checkOutput({name, ".wdata"}, o_bus_wdata, expWdata);
      end
      if (gntDone) sinceGnt++;
      if (i_bus_gnt) gntDone = 1;
      if (!o_stall && cyc > 0) begin
        done = 1;
        g = sb.pop_front();
        checkOutput({name, ".err"},    32'(o_err), 32'(g.err));
        checkOutput({name, ".rvalid"}, 32'(o_rdata_valid), 32'(g.valid));
        if (g.chkRdata) checkOutput({name, ".rdata"}, o_rdata, g.rdata);
        checkOutput({name, ".reqcyc"}, 32'(reqCnt), 32'(g.reqCycles));
        checkOutput({name, ".stalls"}, 32'(stalls), 32'(g.stalls));
      end
    end
    if (!done) begin
      checkOutput({name, ".cycle_bound"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    i_mem_en     = 1'b0;
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_mem_en = 1'b0; i_mem_read = '0; i_mem_write = '0;
    i_mem_sign_ext = 1'b0; i_addr = '0; i_wdata = '0;
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;

    // Reset values
    @(negedge clk); #1;
    checkOutput("rst.req",    32'(o_bus_req), 32'd0);
    checkOutput("rst.be",     32'(o_bus_be), 32'd0);
    checkOutput("rst.addr",   o_bus_addr, 32'd0);
    checkOutput("rst.wdata",  o_bus_wdata, 32'd0);
    checkOutput("rst.rdata",  o_rdata, 32'd0);
    checkOutput("rst.flags",  {29'd0, o_rdata_valid, o_err, o_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads with lane extraction and sign/zero extension
    applyStimulus("lbs",  4'b0001, 4'b0000, 1'b1, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234);
    applyStimulus("lb",   4'b0001, 4'b0000, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234);
    applyStimulus("lh",   4'b0011, 4'b0000, 1'b1, 32'h0000_0002, 32'h0, 1, 2, 32'h8001_0000);
    applyStimulus("lhu",  4'b0011, 4'b0000, 1'b0, 32'h0000_0002, 32'h0, 0, 1, 32'h8001_0000);

    // Stores with delayed grant and lane replication
    applyStimulus("sh",   4'b0000, 4'b0011, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 3, 0, 32'h0);
    applyStimulus("sb",   4'b0000, 4'b0001, 1'b0, 32'h0000_0005, 32'h0000_00AB, 0, 0, 32'h0);

    // Illegal accesses
    applyStimulus("lw_mis", 4'b1111, 4'b0000, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
    applyStimulus("both",   4'b0011, 4'b0001, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
    applyStimulus("badmsk", 4'b0111, 4'b0000, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'h0);

    // Timeout with rvalid withheld, then a stray rvalid in IDLE is ignored
    applyStimulus("lw_tmo", 4'b1111, 4'b0000, 1'b0, 32'h0000_0010, 32'h0, 0, -1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = 32'h1234_5678;
      #1;
      checkOutput("stray.flags", {29'd0, o_rdata_valid, o_err, o_stall}, 32'd0);
    end
    @(negedge clk);
    i_bus_rvalid = 1'b0;
    applyStimulus("lw_ok", 4'b1111, 4'b0000, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'hA5A5_0F0F);

    // Reset asserted while waiting for read data
    @(negedge clk);
    i_mem_en = 1'b1; i_mem_read = 4'b1111; i_mem_write = 4'b0000; i_addr = 32'h0000_0040;
    @(negedge clk);
    i_bus_gnt = o_bus_req;
    @(negedge clk);
    i_bus_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.req",   32'(o_bus_req), 32'd0);
    checkOutput("rstmid.stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    i_mem_en = 1'b0;
    rst_n = 1'b1;
    applyStimulus("lw_reiss", 4'b1111, 4'b0000, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h0BAD_F00D);

    // Back-to-back store then load
    applyStimulus("sw_b2b", 4'b0000, 4'b1111, 1'b0, 32'h0000_3000, 32'h1234_5678, 0, 0, 32'h0);
    applyStimulus("lw_b2b", 4'b1111, 4'b0000, 1'b0, 32'h0000_3000, 32'h0, 0, 0, 32'hCAFE_F00D);

    checkOutput("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder for the pipelined 32-bit CPU.
- Consumes the decoded load/store controls carried down the pipeline: MemRead/MemWrite byte masks, MemSignExtend, ALU address and store data.
- Executes each access on a ready/grant data bus, aligns and extends load data, and stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and data memory.

Parameters:
- TIMEOUT, 64, max cycles spent in REQ+WAIT_R before the access is aborted with an error.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_en  in  1  EX/MEM slot holds a valid instruction.
- mem_read  in  4  read byte mask (0000 none, 0001 byte, 0011 half, 1111 word).
- mem_write  in  4  write byte mask, same encoding.
- mem_sign_ext  in  1  sign-extend load result.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (Rb); only low byte/half are used for SB/SH.
- stall  out  1  combinational; freezes the pipeline.
- rdata  out  32  aligned, extended load result, valid when rdata_valid=1.
- rdata_valid  out  1  one-cycle pulse in RESP for loads.
- err  out  1  one-cycle pulse: misaligned, illegal mask, or timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 for write.
- bus_be  out  4  byte enables.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, rdata_valid and err are all 0; timeout counter is 0.
- An access is requested when mem_en=1 and mem_read|mem_write is nonzero.
- An access is illegal when any of these holds:
  - both masks are nonzero;
  - a mask is outside {0001,0011,1111};
  - a half access has addr[0]=1;
  - a word access has addr[1:0]≠0.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE, legal access: capture op/addr/data, go to REQ. stall=1 this cycle.
- IDLE, illegal access: go to RESP with err armed, no bus activity. stall=1 this cycle.
- IDLE, no access: stall=0.
- REQ:
  - bus_req=1; bus_we/bus_be/bus_addr/bus_wdata are held stable until bus_gnt.
  - On gnt: a write goes to RESP, a read goes to WAIT_R; bus_req drops the cycle after gnt.
  - stall=1.
- WAIT_R: wait for bus_rvalid, then register the extracted data and go to RESP. stall=1.
- RESP:
  - stall=0 so the pipeline advances on this edge.
  - rdata_valid=1 for a successful load; err=1 if an error is armed.
  - Always returns to IDLE; the next op is evaluated in IDLE.
- Lane rules, with o=addr[1:0]:
  - bus_be = mask << o.
  - bus_wdata is replicated per access size: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract:
  - Shift right: s = bus_rdata >> (8*o).
  - Byte: {24{ext},s[7:0]}, where ext = mem_sign_ext & s[7].
  - Half: {16{ext},s[15:0]}, where ext = mem_sign_ext & s[15].
  - Word: s unchanged.
- Timeout:
  - The counter clears on IDLE→REQ and increments each cycle in REQ/WAIT_R.
  - At TIMEOUT: drop bus_req, go to RESP with err=1, rdata=0, rdata_valid=0.
  - A bus_rvalid arriving in any state other than WAIT_R is ignored.
- Minimum latency: write with immediate gnt = 2 stall cycles. Read with gnt and rvalid one cycle apart = 3 stall cycles.
- mem_en=0 while a transaction is in progress: the transaction still completes, because inputs were captured in IDLE.
- Reset mid-transaction: bus_req deasserts asynchronously and the in-flight access is dropped.

Test Plan:
- LBS, addr=0x1003, bus_rdata=0x80FF1234, gnt and rvalid immediate -> bus_be=1000, bus_addr=0x1000; rdata=0xFFFFFF80 with rdata_valid pulse; 3 stall cycles. Repeat as LB -> rdata=0x00000080.
- SH, addr=0x2002, wdata=0xDEADBEEF, gnt delayed 3 cycles -> bus_be=1100, bus_wdata=0xBEEFBEEF, bus_req high 4 cycles with signals stable; stall low in RESP; no rdata_valid.
- LW, addr=0x0006 -> err pulse, bus_req never asserted, 1 stall cycle. mem_read=0011 with mem_write=0001 -> err, no bus access.
- LW, addr=0x10, gnt given, rvalid withheld -> err at cycle TIMEOUT, rdata=0; a later rvalid is ignored and the next LW completes normally.
- rst_n low during WAIT_R -> bus_req=0, stall=0 and state IDLE immediately; after release the same LW reissues cleanly.
- Back-to-back SW then LW with gnt/rvalid immediate -> two separate bus transactions, with exactly one IDLE cycle between them.
